mem_lsu: RTL
============

# mem_lsu

MEM-stage load/store unit sitting between the EX/MEM pipeline register and `dmem`. Decodes RV32I load/store `funct3`, drives the word-only `dmem` port, performs sub-word stores as a two-cycle read-modify-write, and returns aligned, sign- or zero-extended load data into a registered MEM/WB slice. Misaligned or illegal accesses are blocked and flagged.

## Interface
Parameters:
- `XLEN`, 32: data and address width. Only 32 is supported.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: EX/MEM holds a memory instruction this cycle.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: loads use 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores use 000 SB, 001 SH, 010 SW.
- `req_addr` in 32: effective byte address.
- `req_wdata` in 32: store data (rs2).
- `req_rd` in 5: load destination register.
- `stall` out 1: upstream must hold EX/MEM and IF/ID this cycle.
- `mem_memrw` out 1: `dmem` write enable.
- `mem_address` out 32: `dmem` byte address. `dmem` decodes bits [9:2].
- `mem_data_write` out 32: `dmem` write word.
- `mem_data_read` in 32: `dmem` combinational read word.
- `wb_valid` out 1: registered; load result valid for WB.
- `wb_rd` out 5: registered destination register.
- `wb_load_data` out 32: registered extended load value.
- `err` out 1: registered one-cycle pulse on a misaligned or illegal access.

## Operation
- FSM states:
  - IDLE, the reset state.
  - RMW_WR.
- IDLE, word store (SW, `addr[1:0]`=0):
  - `mem_memrw`=1, `mem_data_write`=`req_wdata`.
  - `stall`=0; single cycle.
- IDLE, sub-word store (SB any offset; SH with `addr[0]`=0):
  - `mem_memrw`=0, `stall`=1.
  - Capture `mem_data_read`, address, store data and `funct3` into holding registers.
  - Go to RMW_WR.
- RMW_WR:
  - `mem_address` = held address, `mem_memrw`=1.
  - `mem_data_write` = held word with the target byte/halfword lanes replaced by `wdata[7:0]` or `wdata[15:0]`.
  - `stall`=0. Ignore the still-presented request, which is the same instruction. Return to IDLE.
- IDLE, legal load:
  - `mem_memrw`=0.
  - Next edge: `wb_valid`=1, `wb_rd`=`req_rd`.
  - `wb_load_data` = the lane selected by `addr[1:0]`. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- Fault conditions: LH/LHU/SH with `addr[0]`=1; LW/SW with `addr[1:0]`≠0; load `funct3` ∈ {011,110,111}; store `funct3` > 010.
- On fault:
  - No write and no RMW.
  - `err`=1 on the next edge for one cycle; `wb_valid`=0.
- `req_valid`=0 in IDLE: `mem_memrw`=0, `wb_valid`=0 next cycle.
- No address range check: addresses ≥1 KiB alias in `dmem`.
- `mem_address` = `req_addr` in IDLE and the held address in RMW_WR.

## Timing
- Reset values:
  - state IDLE.
  - `wb_valid`, `wb_rd`, `wb_load_data` and `err` are 0.
  - `stall` and `mem_memrw` are forced 0 while `rst`=1.
- Latencies:
  - Load: 1 cycle, request to `wb_valid`.
  - Word store: 0 extra cycles; the write lands on the request's edge.
  - Sub-word store: 1 stall cycle; the write lands on the second edge.
- `stall` is combinational from state and request. It is high only in IDLE on an accepted sub-word store.
- The RMW read word is registered. There is no same-cycle read→merge→write path.
- Reset in RMW_WR aborts: no write is issued and the state returns to IDLE.
- Back-to-back sub-word stores to the same word each perform their own RMW. The second read sees the first write, so there is no hazard.
- Load immediately after a store to the same word returns the new data, because the write is committed on the prior edge.

## Structure
- Shared package `rv_mem_pkg`:
  - `funct3` localparams: `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`.
  - The `lsu_state_t` enum (IDLE, RMW_WR).
- Sub-module `lsu_align`, purely combinational:
  - Load lane extraction plus extension.
  - Store lane merge.
  - Alignment/legality check producing `fault`.
- `mem_lsu` holds the FSM, holding registers and MEM/WB output registers.

## Test plan
- SW 0xDEADBEEF @0x10, then LW @0x10 → `mem_memrw` high for 1 cycle, no stall; LW gives `wb_valid`=1 next cycle with `wb_load_data`=0xDEADBEEF.
- Word 0x11223344 @0x20, SB 0xAA @0x21 → `stall` high 1 cycle, then write 0x1122AA44; LB @0x21 returns 0xFFFFFFAA, LBU @0x21 returns 0x000000AA.
- SH 0x8001 @0x22 over 0x11223344 → write 0x80013344; LH @0x22 returns 0xFFFF8001, LHU @0x22 returns 0x00008001.
- LW @0x13, SH @0x31 and load `funct3`=011 → no write, `err` one-cycle pulse each, `wb_valid`=0, memory unchanged.
- `rst` asserted during RMW_WR of SB 0x55 @0x40 → no write (word unchanged); after reset, state IDLE and all outputs 0.
- SB @0x50 then SB @0x53 back-to-back, old word 0 → final word 0xBB0000AA with `stall` high once per store.

Source files
------------

// File: rtl/rv_mem_pkg.sv
// rv_mem_pkg: shared funct3 encodings and LSU state type for the MEM stage.
package rv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {IDLE, RMW_WR} lsu_state_t;

endpackage

// File: rtl/mem_lsu_if.sv
// mem_lsu_if: EX/MEM request handshake plus the word-only dmem port.
interface mem_lsu_if #(parameter int XLEN = 32);

    logic            req_valid;
    logic            req_we;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic [4:0]      req_rd;
    logic            stall;
    logic            mem_memrw;
    logic [XLEN-1:0] mem_address;
    logic [XLEN-1:0] mem_data_write;
    logic [XLEN-1:0] mem_data_read;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
        input  stall, mem_memrw, mem_address, mem_data_write,
        output mem_data_read
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
        output stall, mem_memrw, mem_address, mem_data_write,
        input  mem_data_read
    );

endinterface

// File: rtl/lsu_align.sv
// lsu_align: load lane extraction/extension, store lane merge and access legality check.
module lsu_align
    import rv_mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        we,
    input  logic [1:0]  off,
    input  logic [31:0] rdata,
    output logic [31:0] load_data,
    output logic        fault,
    input  logic        st_half,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_word,
    input  logic [15:0] st_wdata,
    output logic [31:0] merge_data
);

    logic [7:0]  lb;
    logic [15:0] lh;
    logic [4:0]  sh_amt;

    assign lb = off[1] ? (off[0] ? rdata[31:24] : rdata[23:16])
                       : (off[0] ? rdata[15:8]  : rdata[7:0]);
    assign lh = off[1] ? rdata[31:16] : rdata[15:0];

    assign load_data = funct3 == F3_B  ? {{24{lb[7]}}, lb} :
                       funct3 == F3_BU ? {24'b0, lb} :
                       funct3 == F3_H  ? {{16{lh[15]}}, lh} :
                       funct3 == F3_HU ? {16'b0, lh} : rdata;

    assign sh_amt = {st_off, 3'b000};

    assign merge_data = st_half ? (st_off[1] ? {st_wdata, st_word[15:0]} : {st_word[31:16], st_wdata})
                                : (st_word & ~(32'hFF << sh_amt)) | ({24'b0, st_wdata[7:0]} << sh_amt);

    // Halfword offsets must be even and words aligned; unused funct3 codes are illegal.
    assign fault = we ? (funct3 > F3_W || (funct3 == F3_H && off[0]) || (funct3 == F3_W && |off))
                      : (funct3 == 3'b011 || funct3[2:1] == 2'b11 ||
                         ((funct3 == F3_H || funct3 == F3_HU) && off[0]) ||
                         (funct3 == F3_W && |off));

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit; sub-word stores run as a two-cycle read-modify-write.
module mem_lsu
    import rv_mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    mem_lsu_if.slave        bus,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_load_data,
    output logic            err
);

    lsu_state_t      state;
    logic [XLEN-1:0] hold_addr;
    logic [XLEN-1:0] hold_word;
    logic [15:0]     hold_wdata;
    logic            hold_half;
    logic            in_rmw, fault, accept, word_st, sub_st;
    logic [31:0]     load_data, merge_data;

    lsu_align u_align (
        .funct3     (bus.req_funct3),
        .we         (bus.req_we),
        .off        (bus.req_addr[1:0]),
        .rdata      (bus.mem_data_read),
        .load_data  (load_data),
        .fault      (fault),
        .st_half    (hold_half),
        .st_off     (hold_addr[1:0]),
        .st_word    (hold_word),
        .st_wdata   (hold_wdata),
        .merge_data (merge_data)
    );

    // In RMW_WR the request still presented is the store being finished, so it is not re-accepted.
    assign in_rmw  = state == RMW_WR;
    assign accept  = !in_rmw && bus.req_valid && !fault;
    assign word_st = accept && bus.req_we && bus.req_funct3 == F3_W;
    assign sub_st  = accept && bus.req_we && bus.req_funct3 != F3_W;

    assign bus.stall          = !rst && sub_st;
    assign bus.mem_memrw      = !rst && (in_rmw || word_st);
    assign bus.mem_address    = in_rmw ? hold_addr : bus.req_addr;
    assign bus.mem_data_write = in_rmw ? merge_data : bus.req_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_load_data <= '0;
            err          <= 1'b0;
        end else begin
            state    <= sub_st ? RMW_WR : IDLE;
            wb_valid <= accept && !bus.req_we;
            err      <= !in_rmw && bus.req_valid && fault;
            if (accept && !bus.req_we) begin
                wb_rd        <= bus.req_rd;
                wb_load_data <= load_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sub_st) begin
            hold_addr  <= bus.req_addr;
            hold_word  <= bus.mem_data_read;
            hold_wdata <= bus.req_wdata[15:0];
            hold_half  <= bus.req_funct3 == F3_H;
        end
    end

endmodule
